// File: rtl/spi_flash_emu_if.sv
// SPI pin bundle and parallel preload port for the spi_flash_emu SPI NOR flash emulator.
interface spi_flash_emu_if #(
    parameter int DEPTH = 256
);
    logic                     spi_csb;
    logic                     spi_sck;
    logic                     spi_mosi;
    logic                     spi_miso;
    logic                     spi_miso_oe;
    logic                     load_we;
    logic [$clog2(DEPTH)-1:0] load_addr;
    logic [7:0]               load_data;
    logic                     busy;
    logic [7:0]               cmd_count;

    modport master (
        output spi_csb, spi_sck, spi_mosi, load_we, load_addr, load_data,
        input  spi_miso, spi_miso_oe, busy, cmd_count
    );

    modport slave (
        input  spi_csb, spi_sck, spi_mosi, load_we, load_addr, load_data,
        output spi_miso, spi_miso_oe, busy, cmd_count
    );
endinterface

// File: rtl/spi_flash_emu.sv
// SPI NOR flash emulator (mode 0, oversampled on clk) serving READ, FAST_READ and RDID.
// Define SPI_FLASH_EMU_PROGRAM_EN to add WREN/WRDI/RDSR/PAGE_PROGRAM.
module spi_flash_emu #(
    parameter int          DEPTH        = 256,
    parameter int          ADDR_BYTES   = 3,
    parameter int          DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4016
) (
    input  logic           clk,
    input  logic           rst,
    spi_flash_emu_if.slave bus
);
    localparam int         AW         = $clog2(DEPTH);
    localparam int         RXW        = (AW > 8) ? AW : 8;
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BYTES * 8 - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE
`ifdef SPI_FLASH_EMU_PROGRAM_EN
        , STATUS, PROG, OPDONE
`endif
    } state_t;

    logic          csb_s1_q, csb_s2_q, csb_prev_q;
    logic          sck_s1_q, sck_s2_q, sck_prev_q;
    logic          mosi_s1_q, mosi_s2_q;
    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [RXW-2:0] rx_q, rx_d;
    logic [RXW-1:0] rx_next;
    logic [23:0]   tx_q, tx_d;
    logic [AW-1:0] addr_q, addr_d, addr_inc;
    logic [7:0]    op_q, op_d;
    logic          miso_q, miso_d, oe_q, oe_d, busy_q, busy_d;
    logic [7:0]    cmd_count_q, cmd_count_d;
    logic          sck_rise, sck_fall, csb_fall;
    logic [7:0]    mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
`ifdef SPI_FLASH_EMU_PROGRAM_EN
    localparam logic [AW-1:0] PAGE_MASK = AW'(15);
    logic          wel_q, wel_d;
`endif

    assign sck_rise = sck_s2_q & ~sck_prev_q;
    assign sck_fall = ~sck_s2_q & sck_prev_q;
    assign csb_fall = csb_prev_q & ~csb_s2_q;
    assign rx_next  = {rx_q, mosi_s2_q};
    assign addr_inc = addr_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        op_d        = op_q;
        miso_d      = miso_q;
        cmd_count_d = cmd_count_q;
        busy_d      = ~csb_s2_q;
        mem_we      = bus.load_we & ~busy_q;
        mem_waddr   = bus.load_addr;
        mem_wdata   = bus.load_data;
`ifdef SPI_FLASH_EMU_PROGRAM_EN
        wel_d       = wel_q;
`endif
        if (csb_s2_q) begin
            // Deselect aborts everything; only the write-enable latch reacts to it.
`ifdef SPI_FLASH_EMU_PROGRAM_EN
            if (state_q == OPDONE && op_q == 8'h06) wel_d = 1'b1;
            if (state_q == OPDONE && op_q == 8'h04) wel_d = 1'b0;
            if (op_q == 8'h02) wel_d = 1'b0;
`endif
            state_d = IDLE;
            cnt_d   = '0;
            rx_d    = '0;
            tx_d    = '0;
            op_d    = '0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (csb_fall) begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
                CMD: if (sck_rise) begin
                    rx_d  = rx_next[RXW-2:0];
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd7) begin
                        cnt_d   = '0;
                        op_d    = rx_next[7:0];
                        state_d = IGNORE;
                        case (rx_next[7:0])
                            8'h03, 8'h0B: begin
                                state_d     = ADDR;
                                cmd_count_d = cmd_count_q + 8'd1;
                            end
                            8'h9F: begin
                                state_d     = ID;
                                tx_d        = JEDEC_ID;
                                cmd_count_d = cmd_count_q + 8'd1;
                            end
`ifdef SPI_FLASH_EMU_PROGRAM_EN
                            8'h04, 8'h06: begin
                                state_d     = OPDONE;
                                cmd_count_d = cmd_count_q + 8'd1;
                            end
                            8'h05: begin
                                state_d     = STATUS;
                                tx_d        = {6'b0, wel_q, 1'b0, 16'h0};
                                cmd_count_d = cmd_count_q + 8'd1;
                            end
                            8'h02: begin
                                state_d     = wel_q ? ADDR : IGNORE;
                                cmd_count_d = cmd_count_q + 8'd1;
                            end
`endif
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: if (sck_rise) begin
                    rx_d  = rx_next[RXW-2:0];
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        addr_d  = rx_next[AW-1:0];
                        tx_d    = {mem_q[rx_next[AW-1:0]], 16'h0};
                        state_d = ((op_q == 8'h0B) && (DUMMY_CYCLES != 0)) ? DUMMY : DATA;
`ifdef SPI_FLASH_EMU_PROGRAM_EN
                        if (op_q == 8'h02) state_d = PROG;
`endif
                    end
                end
                DUMMY: if (sck_rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end
                end
                DATA: if (sck_fall) begin
                    miso_d = tx_q[23];
                    cnt_d  = cnt_q + 8'd1;
                    tx_d   = {tx_q[22:0], 1'b0};
                    if (cnt_q == 8'd7) begin
                        cnt_d  = '0;
                        addr_d = addr_inc;
                        tx_d   = {mem_q[addr_inc], 16'h0};
                    end
                end
                ID: if (sck_fall) begin
                    miso_d = tx_q[23];
                    tx_d   = {tx_q[22:0], 1'b0};
                end
`ifdef SPI_FLASH_EMU_PROGRAM_EN
                STATUS: if (sck_fall) begin
                    miso_d = tx_q[23];
                    cnt_d  = cnt_q + 8'd1;
                    tx_d   = {tx_q[22:0], 1'b0};
                    if (cnt_q == 8'd7) begin
                        cnt_d = '0;
                        tx_d  = {6'b0, wel_q, 1'b0, 16'h0};
                    end
                end
                PROG: if (sck_rise) begin
                    rx_d  = rx_next[RXW-2:0];
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd7) begin
                        // Programming can only clear bits; address wraps inside the 16-byte page.
                        cnt_d     = '0;
                        mem_we    = 1'b1;
                        mem_waddr = addr_q;
                        mem_wdata = mem_q[addr_q] & rx_next[7:0];
                        addr_d    = (addr_q & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
                    end
                end
                OPDONE: if (sck_rise) state_d = IGNORE;
`endif
                IGNORE:  state_d = IGNORE;
                default: state_d = IDLE;
            endcase
        end
        oe_d = (state_d == DATA) || (state_d == ID);
`ifdef SPI_FLASH_EMU_PROGRAM_EN
        oe_d = oe_d || (state_d == STATUS);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb_s1_q    <= 1'b1;
            csb_s2_q    <= 1'b1;
            csb_prev_q  <= 1'b1;
            sck_s1_q    <= 1'b0;
            sck_s2_q    <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            op_q        <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            cmd_count_q <= '0;
`ifdef SPI_FLASH_EMU_PROGRAM_EN
            wel_q       <= 1'b0;
`endif
        end else begin
            csb_s1_q    <= bus.spi_csb;
            csb_s2_q    <= csb_s1_q;
            csb_prev_q  <= csb_s2_q;
            sck_s1_q    <= bus.spi_sck;
            sck_s2_q    <= sck_s1_q;
            sck_prev_q  <= sck_s2_q;
            mosi_s1_q   <= bus.spi_mosi;
            mosi_s2_q   <= mosi_s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            cmd_count_q <= cmd_count_d;
`ifdef SPI_FLASH_EMU_PROGRAM_EN
            wel_q       <= wel_d;
`endif
        end
    end

    // The array has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.busy        = busy_q;
    assign bus.cmd_count   = cmd_count_q;
endmodule

// File: tb/tb_spi_flash_emu.sv
// Directed, scoreboard-checked bench for spi_flash_emu (SPI_FLASH_EMU_PROGRAM_EN adds program checks).
module tb_spi_flash_emu;
    localparam int          HALF = 5;
    localparam logic [23:0] ID   = 24'hEF4016;

    logic       clk;
    logic       rst;
    int         test_count = 0;
    int         fail_count = 0;
    int         exp_count  = 0;
    logic [7:0] model_mem [256];
    logic [7:0] sb_q [$];
`ifdef SPI_FLASH_EMU_PROGRAM_EN
    logic       model_wel = 1'b0;
`endif

    spi_flash_emu_if #(.DEPTH(256)) bus ();

    spi_flash_emu #(
        .DEPTH(256), .ADDR_BYTES(3), .DUMMY_CYCLES(8), .JEDEC_ID(ID)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end of run, expected $finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        test_count++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_sb(input string tag, input logic [7:0] obs);
        logic [7:0] expb;
        if (sb_q.size() == 0) begin
            test_count++;
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected nothing queued", tag, obs);
        end else begin
            expb = sb_q.pop_front();
            check_output(tag, 32'(obs), 32'(expb));
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] d);
        bus.load_we   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        @(negedge clk);
        bus.load_we   = 1'b0;
        model_mem[a]  = d;
    endtask

    // One mode-0 bit per iteration: miso is sampled just before the rising edge.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                        output logic oe_any, output logic oe_all);
        rx     = '0;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx     = {rx[6:0], bus.spi_miso};
            oe_any = oe_any | bus.spi_miso_oe;
            oe_all = oe_all & bus.spi_miso_oe;
            bus.spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        bus.spi_csb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        bus.spi_csb = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_addr(input logic [7:0] a);
        logic [7:0] rx;
        logic       oa, ol;
        xfer(8'h00, 8, rx, oa, ol);
        xfer(8'h00, 8, rx, oa, ol);
        xfer(a, 8, rx, oa, ol);
    endtask

    task automatic spi_read(input logic [7:0] op, input logic [7:0] a, input int nbytes, input string tag);
        logic [7:0] rx;
        logic       oa, ol;
        cs_low();
        xfer(op, 8, rx, oa, ol);
        send_addr(a);
        if (op == 8'h0B) begin
            xfer(8'h00, 8, rx, oa, ol);
            check_output({tag, " dummy oe"}, 32'(oa), 32'd0);
        end
        for (int k = 0; k < nbytes; k++) begin
            sb_q.push_back(model_mem[8'(a + k)]);
            xfer(8'h00, 8, rx, oa, ol);
            check_output({tag, " data oe"}, 32'(ol), 32'd1);
            check_sb(tag, rx);
        end
        cs_high();
        exp_count++;
    endtask

    initial begin
        logic [7:0] rx;
        logic       oa, ol;

        rst = 1'b1;
        bus.spi_csb   = 1'b1;
        bus.spi_sck   = 1'b0;
        bus.spi_mosi  = 1'b0;
        bus.load_we   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        repeat (3) @(negedge clk);
        check_output("reset miso", 32'(bus.spi_miso), 32'd0);
        check_output("reset oe", 32'(bus.spi_miso_oe), 32'd0);
        check_output("reset busy", 32'(bus.busy), 32'd0);
        check_output("reset cmd_count", 32'(bus.cmd_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 256; i++) apply_stimulus(8'(i), 8'(i));
        apply_stimulus(8'h10, 8'hA5);
        apply_stimulus(8'h20, 8'hF3);

        // RDID followed by the busy release timing after deselect
        cs_low();
        check_output("busy while selected", 32'(bus.busy), 32'd1);
        xfer(8'h9F, 8, rx, oa, ol);
        sb_q.push_back(ID[23:16]);
        sb_q.push_back(ID[15:8]);
        sb_q.push_back(ID[7:0]);
        for (int k = 0; k < 3; k++) begin
            xfer(8'h00, 8, rx, oa, ol);
            check_sb("rdid byte", rx);
        end
        repeat (HALF) @(negedge clk);
        bus.spi_csb = 1'b1;
        @(negedge clk);
        check_output("busy 1 clk after csb rise", 32'(bus.busy), 32'd1);
        repeat (2) @(negedge clk);
        check_output("busy 3 clk after csb rise", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        exp_count++;
        check_output("cmd_count after rdid", 32'(bus.cmd_count), 32'(exp_count));

        spi_read(8'h03, 8'hFE, 4, "read wrap");
        spi_read(8'h0B, 8'h10, 1, "fast_read");
        check_output("cmd_count after fast_read", 32'(bus.cmd_count), 32'(exp_count));

        // READ aborted after 12 bits, then a clean READ
        cs_low();
        xfer(8'h03, 8, rx, oa, ol);
        xfer(8'h00, 4, rx, oa, ol);
        cs_high();
        exp_count++;
        spi_read(8'h03, 8'h03, 1, "read after abort");

        cs_low();
        xfer(8'h55, 8, rx, oa, ol);
        xfer(8'h00, 8, rx, oa, ol);
        check_output("bad opcode oe", 32'(oa), 32'd0);
        cs_high();
        check_output("cmd_count after bad opcode", 32'(bus.cmd_count), 32'(exp_count));

        // Load attempt during an SCK-less select must be ignored and not counted
        cs_low();
        bus.load_we   = 1'b1;
        bus.load_addr = 8'h03;
        bus.load_data = 8'hEE;
        @(negedge clk);
        bus.load_we   = 1'b0;
        cs_high();
        check_output("cmd_count after empty select", 32'(bus.cmd_count), 32'(exp_count));
        spi_read(8'h03, 8'h03, 1, "read after busy load");

        // Reset in the middle of the second data byte
        cs_low();
        xfer(8'h03, 8, rx, oa, ol);
        send_addr(8'h40);
        sb_q.push_back(model_mem[8'h40]);
        xfer(8'h00, 8, rx, oa, ol);
        check_sb("read before reset", rx);
        xfer(8'h00, 3, rx, oa, ol);
        check_output("oe before reset", 32'(bus.spi_miso_oe), 32'd1);
        rst = 1'b1;
        #1;
        exp_count = 0;
        check_output("mid reset miso", 32'(bus.spi_miso), 32'd0);
        check_output("mid reset oe", 32'(bus.spi_miso_oe), 32'd0);
        check_output("mid reset busy", 32'(bus.busy), 32'd0);
        check_output("mid reset cmd_count", 32'(bus.cmd_count), 32'd0);
        bus.spi_csb = 1'b1;
        bus.spi_sck = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        spi_read(8'h03, 8'h40, 2, "read after reset");
        check_output("cmd_count after reset read", 32'(bus.cmd_count), 32'(exp_count));

`ifdef SPI_FLASH_EMU_PROGRAM_EN
        // PAGE_PROGRAM without WREN is refused
        cs_low();
        xfer(8'h02, 8, rx, oa, ol);
        send_addr(8'h20);
        xfer(8'h0F, 8, rx, oa, ol);
        cs_high();
        exp_count++;
        if (model_wel) model_mem[8'h20] = model_mem[8'h20] & 8'h0F;
        model_wel = 1'b0;
        spi_read(8'h03, 8'h20, 1, "read after refused program");

        cs_low();
        xfer(8'h06, 8, rx, oa, ol);
        cs_high();
        exp_count++;
        model_wel = 1'b1;

        cs_low();
        xfer(8'h05, 8, rx, oa, ol);
        sb_q.push_back({6'b0, model_wel, 1'b0});
        xfer(8'h00, 8, rx, oa, ol);
        check_sb("rdsr after wren", rx);
        cs_high();
        exp_count++;

        cs_low();
        xfer(8'h02, 8, rx, oa, ol);
        send_addr(8'h20);
        xfer(8'h0F, 8, rx, oa, ol);
        cs_high();
        exp_count++;
        if (model_wel) model_mem[8'h20] = model_mem[8'h20] & 8'h0F;
        model_wel = 1'b0;
        spi_read(8'h03, 8'h20, 1, "read after program");

        cs_low();
        xfer(8'h05, 8, rx, oa, ol);
        sb_q.push_back({6'b0, model_wel, 1'b0});
        xfer(8'h00, 8, rx, oa, ol);
        check_sb("rdsr after program", rx);
        cs_high();
        exp_count++;
        check_output("cmd_count after program ops", 32'(bus.cmd_count), 32'(exp_count));
`else
        cs_low();
        xfer(8'h05, 8, rx, oa, ol);
        xfer(8'h00, 8, rx, oa, ol);
        check_output("rdsr disabled oe", 32'(oa), 32'd0);
        cs_high();
        check_output("cmd_count after disabled rdsr", 32'(bus.cmd_count), 32'(exp_count));
`endif

        check_output("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
